// File: rtl/dispatcher_4rd_8tag_pkg.sv
// Shared constants for the 4-slave tagged-read dispatcher: credit limits,
// slave count, FSM encoding and the slave-select decode helper.
package dispatcher_4rd_8tag_pkg;

   localparam int BUFSIZE_POW     = 3;
   localparam int MAX_OUTSTANDING = 8;
   localparam int NUM_SLAVES      = 4;
   localparam int CNT_WIDTH       = 4;

   // Two-state FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   typedef logic [1:0] slave_sel_t;

   // Decode the two top address bits into a one-hot slave request vector
   function automatic logic [NUM_SLAVES-1:0] slave_onehot(input slave_sel_t sel);
      logic [NUM_SLAVES-1:0] oh;
      case (sel)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/dispatcher_4rd_8tag_tag_alloc.sv
// Read-credit and tag allocator: hands out tags modulo 2^TAG_WIDTH, counts
// reads in flight (0..MAX_OUTSTANDING) and flags a retire with nothing in flight.
module tag_alloc
   import dispatcher_4rd_8tag_pkg::*;
#(
   parameter int TAG_WIDTH = BUFSIZE_POW
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 alloc,
   input  logic                 retire,
   output logic [TAG_WIDTH-1:0] tag,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 can_alloc,
   output logic                 err
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [TAG_WIDTH-1:0] TAG_ZERO = {TAG_WIDTH{1'b0}};
   localparam logic [TAG_WIDTH-1:0] TAG_ONE  = TAG_WIDTH'(1);

   logic [TAG_WIDTH-1:0] tag_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 err_r;
   logic                 can_alloc_s;
   logic                 alloc_ok_s;
   logic                 retire_ok_s;
   logic                 retire_bad_s;
   logic [CNT_WIDTH-1:0] count_nxt_s;

   // Credit check uses only the registered count so a same-cycle retire never frees a slot early
   always_comb begin
      can_alloc_s  = (count_r < CNT_MAX);
      alloc_ok_s   = alloc && can_alloc_s;
      retire_ok_s  = retire && (count_r != CNT_ZERO);
      retire_bad_s = retire && (count_r == CNT_ZERO);
      case ({alloc_ok_s, retire_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Tag counter, outstanding counter and sticky underflow error
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_r   <= TAG_ZERO;
         count_r <= CNT_ZERO;
         err_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (alloc_ok_s) begin
            tag_r <= tag_r + TAG_ONE;
         end
         if (retire_bad_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign tag       = tag_r;
   assign count     = count_r;
   assign can_alloc = can_alloc_s;
   assign err       = err_r;

endmodule

// File: rtl/dispatcher_4rd_8tag.sv
// Host-to-4-slave command dispatcher. Reads are tagged and credit-limited to
// MAX_OUTSTANDING in flight; each read tag is pushed to the sequencer tag FIFO
// on accept. Writes go through untagged and without credit.
module dispatcher_4rd_8tag
   import dispatcher_4rd_8tag_pkg::*;
#(
   parameter int TAG_WIDTH  = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  host_req_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_bi,
   input  logic [DATA_WIDTH-1:0] host_wdata_bi,
   output logic                  host_ack_o,
   output logic                  req0_o,
   input  logic                  ack0_i,
   output logic                  we0_o,
   output logic [ADDR_WIDTH-1:0] addr0_bo,
   output logic [DATA_WIDTH-1:0] wdata0_bo,
   output logic [TAG_WIDTH-1:0]  tag0_bo,
   output logic                  req1_o,
   input  logic                  ack1_i,
   output logic                  we1_o,
   output logic [ADDR_WIDTH-1:0] addr1_bo,
   output logic [DATA_WIDTH-1:0] wdata1_bo,
   output logic [TAG_WIDTH-1:0]  tag1_bo,
   output logic                  req2_o,
   input  logic                  ack2_i,
   output logic                  we2_o,
   output logic [ADDR_WIDTH-1:0] addr2_bo,
   output logic [DATA_WIDTH-1:0] wdata2_bo,
   output logic [TAG_WIDTH-1:0]  tag2_bo,
   output logic                  req3_o,
   input  logic                  ack3_i,
   output logic                  we3_o,
   output logic [ADDR_WIDTH-1:0] addr3_bo,
   output logic [DATA_WIDTH-1:0] wdata3_bo,
   output logic [TAG_WIDTH-1:0]  tag3_bo,
   input  logic                  tag_fifo_full_i,
   output logic                  tag_fifo_wrreq_o,
   output logic [TAG_WIDTH-1:0]  tag_fifo_wdata_bo,
   input  logic                  rsp_i,
   output logic [3:0]            outstanding_bo,
   output logic                  err_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [TAG_WIDTH-1:0]  TAG_ZERO  = {TAG_WIDTH{1'b0}};

   logic [0:0]            state_r;
   logic                  we_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [TAG_WIDTH-1:0]  tag_r;
   logic [NUM_SLAVES-1:0] req_r;

   slave_sel_t            sel_s;
   logic [NUM_SLAVES-1:0] ack_s;
   logic                  accept_s;
   logic                  rd_accept_s;
   logic                  slave_done_s;
   logic [TAG_WIDTH-1:0]  tag_s;
   logic [CNT_WIDTH-1:0]  count_s;
   logic                  can_alloc_s;
   logic                  err_s;

   assign sel_s = host_addr_bi[ADDR_WIDTH-1 -: 2];
   assign ack_s = {ack3_i, ack2_i, ack1_i, ack0_i};

   // Accept decision: IDLE only; reads also need a credit and room in the tag FIFO
   always_comb begin
      accept_s = 1'b0;
      if ((state_r == ST_IDLE) && host_req_i) begin
         if (host_we_i) begin
            accept_s = 1'b1;
         end else begin
            accept_s = can_alloc_s && !tag_fifo_full_i;
         end
      end else begin
         accept_s = 1'b0;
      end
      rd_accept_s  = accept_s && !host_we_i;
      // Only the acknowledge of the slave currently being requested counts
      slave_done_s = (state_r == ST_ISSUE) && ((req_r & ack_s) != {NUM_SLAVES{1'b0}});
   end

   tag_alloc #(
      .TAG_WIDTH (TAG_WIDTH)
   ) u_tag_alloc (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .alloc     (rd_accept_s),
      .retire    (rsp_i),
      .tag       (tag_s),
      .count     (count_s),
      .can_alloc (can_alloc_s),
      .err       (err_s)
   );

   // FSM: latch the command on accept, hold the slave request until that slave acks
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         we_r    <= 1'b0;
         addr_r  <= ADDR_ZERO;
         wdata_r <= DATA_ZERO;
         tag_r   <= TAG_ZERO;
         req_r   <= {NUM_SLAVES{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_r <= ST_ISSUE;
                  req_r   <= slave_onehot(sel_s);
                  we_r    <= host_we_i;
                  addr_r  <= host_addr_bi;
                  wdata_r <= host_we_i ? host_wdata_bi : DATA_ZERO;
                  tag_r   <= host_we_i ? TAG_ZERO : tag_s;
               end
            end
            ST_ISSUE: begin
               if (slave_done_s) begin
                  state_r <= ST_IDLE;
                  req_r   <= {NUM_SLAVES{1'b0}};
               end
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= {NUM_SLAVES{1'b0}};
            end
         endcase
      end
   end

   assign host_ack_o        = accept_s;
   assign tag_fifo_wrreq_o  = rd_accept_s;
   assign tag_fifo_wdata_bo = rd_accept_s ? tag_s : TAG_ZERO;
   assign outstanding_bo    = count_s;
   assign err_o             = err_s;

   // Per-slave command fields are the latched command masked by that slave's request bit
   assign req0_o    = req_r[0];
   assign we0_o     = req_r[0] & we_r;
   assign addr0_bo  = req_r[0] ? addr_r  : ADDR_ZERO;
   assign wdata0_bo = req_r[0] ? wdata_r : DATA_ZERO;
   assign tag0_bo   = req_r[0] ? tag_r   : TAG_ZERO;

   assign req1_o    = req_r[1];
   assign we1_o     = req_r[1] & we_r;
   assign addr1_bo  = req_r[1] ? addr_r  : ADDR_ZERO;
   assign wdata1_bo = req_r[1] ? wdata_r : DATA_ZERO;
   assign tag1_bo   = req_r[1] ? tag_r   : TAG_ZERO;

   assign req2_o    = req_r[2];
   assign we2_o     = req_r[2] & we_r;
   assign addr2_bo  = req_r[2] ? addr_r  : ADDR_ZERO;
   assign wdata2_bo = req_r[2] ? wdata_r : DATA_ZERO;
   assign tag2_bo   = req_r[2] ? tag_r   : TAG_ZERO;

   assign req3_o    = req_r[3];
   assign we3_o     = req_r[3] & we_r;
   assign addr3_bo  = req_r[3] ? addr_r  : ADDR_ZERO;
   assign wdata3_bo = req_r[3] ? wdata_r : DATA_ZERO;
   assign tag3_bo   = req_r[3] ? tag_r   : TAG_ZERO;

endmodule

// File: tb/tb_dispatcher_4rd_8tag.sv
// Directed self-checking bench for dispatcher_4rd_8tag. Inputs change on the
// falling edge; outputs are sampled at or just after the falling edge.
module tb_dispatcher_4rd_8tag;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_req, host_we;
   logic [31:0] host_addr, host_wdata;
   logic        host_ack;
   logic [3:0]  req, we, ack;
   logic [31:0] slv_addr  [4];
   logic [31:0] slv_wdata [4];
   logic [2:0]  slv_tag   [4];
   logic        fifo_full, fifo_wrreq;
   logic [2:0]  fifo_wdata;
   logic        rsp;
   logic [3:0]  outstanding;
   logic        err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic       got, push;
   logic [2:0] ptag;

   always #5 clk = ~clk;

   dispatcher_4rd_8tag dut (
      .clk_i (clk), .rst_i (rst),
      .host_req_i (host_req), .host_we_i (host_we),
      .host_addr_bi (host_addr), .host_wdata_bi (host_wdata), .host_ack_o (host_ack),
      .req0_o (req[0]), .ack0_i (ack[0]), .we0_o (we[0]),
      .addr0_bo (slv_addr[0]), .wdata0_bo (slv_wdata[0]), .tag0_bo (slv_tag[0]),
      .req1_o (req[1]), .ack1_i (ack[1]), .we1_o (we[1]),
      .addr1_bo (slv_addr[1]), .wdata1_bo (slv_wdata[1]), .tag1_bo (slv_tag[1]),
      .req2_o (req[2]), .ack2_i (ack[2]), .we2_o (we[2]),
      .addr2_bo (slv_addr[2]), .wdata2_bo (slv_wdata[2]), .tag2_bo (slv_tag[2]),
      .req3_o (req[3]), .ack3_i (ack[3]), .we3_o (we[3]),
      .addr3_bo (slv_addr[3]), .wdata3_bo (slv_wdata[3]), .tag3_bo (slv_tag[3]),
      .tag_fifo_full_i (fifo_full), .tag_fifo_wrreq_o (fifo_wrreq),
      .tag_fifo_wdata_bo (fifo_wdata),
      .rsp_i (rsp), .outstanding_bo (outstanding), .err_o (err)
   );

   // Stimulus: present a host command from a falling edge, wait up to max_wait cycles for ack
   task automatic issue(input logic we_in, input logic [31:0] a, input logic [31:0] d,
                        input int max_wait, output logic g, output logic p, output logic [2:0] t);
      g = 1'b0; p = 1'b0; t = 3'd0;
      host_we = we_in; host_addr = a; host_wdata = d; host_req = 1'b1;
      for (int i = 0; i < max_wait; i++) begin
         #1;
         if (host_ack === 1'b1) begin g = 1'b1; p = fifo_wrreq; t = fifo_wdata; end
         @(negedge clk);
         if (g) break;
      end
      host_req = 1'b0;
   endtask

   task automatic slave_accept(input int n);
      ack[n] = 1'b1;
      @(negedge clk);
      ack[n] = 1'b0;
   endtask

   task automatic pulse_rsp();
      rsp = 1'b1;
      @(negedge clk);
      rsp = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      tests_run++; if (req !== 4'b0000) begin tests_failed++; $display("FAIL reset_req: got %b want 0000", req); end
      tests_run++; if (outstanding !== 4'd0) begin tests_failed++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if (host_ack !== 1'b0 || fifo_wrreq !== 1'b0) begin tests_failed++; $display("FAIL idle_strobes: got ack=%b wrreq=%b want 0 0", host_ack, fifo_wrreq); end
   endtask

   task automatic test_single_read();
      issue(1'b0, 32'h4000_0000, 32'h0, 1, got, push, ptag);
      tests_run++; if (got !== 1'b1 || push !== 1'b1 || ptag !== 3'd0) begin tests_failed++; $display("FAIL rd_accept: got ack=%b push=%b tag=%0d want 1 1 0", got, push, ptag); end
      tests_run++; if (req !== 4'b0010) begin tests_failed++; $display("FAIL rd_req1: got %b want 0010", req); end
      tests_run++; if (slv_addr[1] !== 32'h4000_0000 || slv_tag[1] !== 3'd0 || we[1] !== 1'b0) begin tests_failed++; $display("FAIL rd_fields1: got addr=%h tag=%0d we=%b want 40000000 0 0", slv_addr[1], slv_tag[1], we[1]); end
      tests_run++; if (slv_addr[0] !== 32'h0 || slv_addr[2] !== 32'h0) begin tests_failed++; $display("FAIL rd_unsel_zero: got a0=%h a2=%h want 0 0", slv_addr[0], slv_addr[2]); end
      tests_run++; if (outstanding !== 4'd1) begin tests_failed++; $display("FAIL rd_outstanding: got %0d want 1", outstanding); end
      host_req = 1'b1; host_we = 1'b1;
      #1;
      tests_run++; if (host_ack !== 1'b0 || fifo_wrreq !== 1'b0) begin tests_failed++; $display("FAIL issue_no_ack: got ack=%b wrreq=%b want 0 0", host_ack, fifo_wrreq); end
      @(negedge clk);
      host_req = 1'b0;
      tests_run++; if (req !== 4'b0010) begin tests_failed++; $display("FAIL rd_req_hold: got %b want 0010", req); end
      slave_accept(1);
      tests_run++; if (req !== 4'b0000) begin tests_failed++; $display("FAIL rd_req_drop: got %b want 0000", req); end
   endtask

   task automatic test_eight_reads();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 32'h0000_0100, 32'h0, 2, got, push, ptag);
         tests_run++; if (got !== 1'b1 || push !== 1'b1 || ptag !== 3'(i)) begin tests_failed++; $display("FAIL rd8_tag%0d: got ack=%b push=%b tag=%0d want 1 1 %0d", i, got, push, ptag, i); end
         slave_accept(0);
      end
      tests_run++; if (outstanding !== 4'd8) begin tests_failed++; $display("FAIL rd8_outstanding: got %0d want 8", outstanding); end
      host_we = 1'b0; host_addr = 32'h0000_0200; host_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (host_ack !== 1'b0) begin tests_failed++; $display("FAIL rd9_stall%0d: got ack=%b want 0", i, host_ack); end
         @(negedge clk);
      end
      rsp = 1'b1;
      #1;
      tests_run++; if (host_ack !== 1'b0) begin tests_failed++; $display("FAIL rd9_same_cycle_rsp: got ack=%b want 0", host_ack); end
      @(negedge clk);
      rsp = 1'b0;
      #1;
      tests_run++; if (host_ack !== 1'b1 || fifo_wrreq !== 1'b1 || fifo_wdata !== 3'd0) begin tests_failed++; $display("FAIL rd9_accept: got ack=%b wrreq=%b tag=%0d want 1 1 0", host_ack, fifo_wrreq, fifo_wdata); end
      @(negedge clk);
      host_req = 1'b0;
      tests_run++; if (outstanding !== 4'd8) begin tests_failed++; $display("FAIL rd9_outstanding: got %0d want 8", outstanding); end
      slave_accept(0);
   endtask

   task automatic test_write();
      issue(1'b1, 32'hC000_0010, 32'hDEAD_BEEF, 1, got, push, ptag);
      tests_run++; if (got !== 1'b1 || push !== 1'b0) begin tests_failed++; $display("FAIL wr_accept: got ack=%b push=%b want 1 0", got, push); end
      tests_run++; if (req !== 4'b1000 || we[3] !== 1'b1) begin tests_failed++; $display("FAIL wr_req3: got req=%b we3=%b want 1000 1", req, we[3]); end
      tests_run++; if (slv_wdata[3] !== 32'hDEAD_BEEF || slv_addr[3] !== 32'hC000_0010 || slv_tag[3] !== 3'd0) begin tests_failed++; $display("FAIL wr_fields3: got d=%h a=%h t=%0d want deadbeef c0000010 0", slv_wdata[3], slv_addr[3], slv_tag[3]); end
      tests_run++; if (slv_wdata[0] !== 32'h0 || we[0] !== 1'b0) begin tests_failed++; $display("FAIL wr_unsel_zero: got d0=%h we0=%b want 0 0", slv_wdata[0], we[0]); end
      tests_run++; if (outstanding !== 4'd8) begin tests_failed++; $display("FAIL wr_outstanding: got %0d want 8", outstanding); end
      slave_accept(3);
      tests_run++; if (req !== 4'b0000) begin tests_failed++; $display("FAIL wr_req_drop: got %b want 0000", req); end
   endtask

   task automatic test_back_to_back();
      host_we = 1'b1; host_addr = 32'h4000_0040; host_wdata = 32'h1234_5678; host_req = 1'b1;
      #1;
      tests_run++; if (host_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_first: got ack=%b want 1", host_ack); end
      @(negedge clk);
      #1;
      tests_run++; if (host_ack !== 1'b0 || req !== 4'b0010) begin tests_failed++; $display("FAIL b2b_issue: got ack=%b req=%b want 0 0010", host_ack, req); end
      ack[1] = 1'b1;
      @(negedge clk);
      ack[1] = 1'b0;
      #1;
      tests_run++; if (host_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_second: got ack=%b want 1", host_ack); end
      @(negedge clk);
      host_req = 1'b0;
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      tests_run++; if (req !== 4'b0010) begin tests_failed++; $display("FAIL unsel_ack_ignored: got %b want 0010", req); end
      slave_accept(1);
      for (int i = 0; i < 5; i++) pulse_rsp();
      tests_run++; if (outstanding !== 4'd3) begin tests_failed++; $display("FAIL drain_to_3: got %0d want 3", outstanding); end
   endtask

   task automatic test_fifo_full();
      fifo_full = 1'b1;
      host_we = 1'b0; host_addr = 32'h8000_0000; host_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         tests_run++; if (host_ack !== 1'b0) begin tests_failed++; $display("FAIL full_rd_stall%0d: got ack=%b want 0", i, host_ack); end
         @(negedge clk);
      end
      host_we = 1'b1; host_addr = 32'h4000_0000; host_wdata = 32'hA5A5_A5A5;
      #1;
      tests_run++; if (host_ack !== 1'b1 || fifo_wrreq !== 1'b0) begin tests_failed++; $display("FAIL full_wr_accept: got ack=%b wrreq=%b want 1 0", host_ack, fifo_wrreq); end
      @(negedge clk);
      host_req = 1'b0;
      slave_accept(1);
      host_we = 1'b0; host_addr = 32'h8000_0000; host_req = 1'b1;
      #1;
      tests_run++; if (host_ack !== 1'b0) begin tests_failed++; $display("FAIL full_rd_again: got ack=%b want 0", host_ack); end
      @(negedge clk);
      fifo_full = 1'b0;
      #1;
      tests_run++; if (host_ack !== 1'b1 || fifo_wdata !== 3'd1) begin tests_failed++; $display("FAIL full_drop_accept: got ack=%b tag=%0d want 1 1", host_ack, fifo_wdata); end
      @(negedge clk);
      host_req = 1'b0;
      tests_run++; if (req !== 4'b0100 || outstanding !== 4'd4) begin tests_failed++; $display("FAIL full_rd_issue: got req=%b out=%0d want 0100 4", req, outstanding); end
      slave_accept(2);
   endtask

   task automatic test_simul_and_err();
      pulse_rsp();
      tests_run++; if (outstanding !== 4'd3) begin tests_failed++; $display("FAIL simul_pre: got %0d want 3", outstanding); end
      host_we = 1'b0; host_addr = 32'h0000_0000; host_req = 1'b1; rsp = 1'b1;
      #1;
      tests_run++; if (host_ack !== 1'b1) begin tests_failed++; $display("FAIL simul_accept: got ack=%b want 1", host_ack); end
      @(negedge clk);
      rsp = 1'b0; host_req = 1'b0;
      tests_run++; if (outstanding !== 4'd3 || slv_tag[0] !== 3'd2) begin tests_failed++; $display("FAIL simul_count: got out=%0d tag=%0d want 3 2", outstanding, slv_tag[0]); end
      slave_accept(0);
      for (int i = 0; i < 3; i++) pulse_rsp();
      tests_run++; if (outstanding !== 4'd0 || err !== 1'b0) begin tests_failed++; $display("FAIL drain_to_0: got out=%0d err=%b want 0 0", outstanding, err); end
      pulse_rsp();
      tests_run++; if (outstanding !== 4'd0 || err !== 1'b1) begin tests_failed++; $display("FAIL underflow: got out=%0d err=%b want 0 1", outstanding, err); end
      @(negedge clk);
      @(negedge clk);
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_mid_issue();
      issue(1'b0, 32'h8000_0000, 32'h0, 1, got, push, ptag);
      tests_run++; if (got !== 1'b1 || ptag !== 3'd3 || req !== 4'b0100) begin tests_failed++; $display("FAIL mid_pre: got ack=%b tag=%0d req=%b want 1 3 0100", got, ptag, req); end
      #2;
      rst = 1'b1;
      #1;
      tests_run++; if (req !== 4'b0000 || outstanding !== 4'd0 || err !== 1'b0) begin tests_failed++; $display("FAIL mid_async_reset: got req=%b out=%0d err=%b want 0000 0 0", req, outstanding, err); end
      @(negedge clk);
      rst = 1'b0;
      issue(1'b0, 32'h8000_0000, 32'h0, 1, got, push, ptag);
      tests_run++; if (got !== 1'b1 || ptag !== 3'd0 || outstanding !== 4'd1) begin tests_failed++; $display("FAIL post_reset_tag: got ack=%b tag=%0d out=%0d want 1 0 1", got, ptag, outstanding); end
      slave_accept(2);
   endtask

   initial begin
      rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
      ack = 4'b0000; fifo_full = 1'b0; rsp = 1'b0;
      test_reset();
      test_single_read();
      test_eight_reads();
      test_write();
      test_back_to_back();
      test_fifo_full();
      test_simul_and_err();
      test_reset_mid_issue();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
